// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN          : machine word width used by fetch entries
//   NOP           : ADDI x0,x0,0, presented to decode when no instruction is buffered
//   fetch_state_t : fetch FSM states (IDLE / WAIT / DISCARD)
//   fetch_entry_t : one buffered instruction with its PC
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // nothing outstanding
        WAIT    = 2'd1,  // one request outstanding
        DISCARD = 2'd2   // outstanding response belongs to a flushed path
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetch entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry (taken when not full, or full with a pop)
//   push_entry  : entry to write
//   pop         : drop head entry (ignored when empty)
//   flush       : empty the queue; overrides push and pop
//   head        : entry at the head (meaningful only when !empty)
//   count       : number of buffered entries
//   empty, full : occupancy flags
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  fetch_entry_t      push_entry,
    input  logic              pop,
    input  logic              flush,
    output fetch_entry_t      head,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head is only looked at when the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues word reads to
// instruction memory with at most one request in flight, buffers returned
// words with their PCs and presents one instruction per cycle to decode.
// Redirects from execute flush buffered and in-flight instructions.
//
// Handshake: decode takes the instruction on instr_o/pc_o in every cycle
// where valid_o && ready_i; valid_o never depends on ready_i. Memory
// requests (imem_req_o) are always accepted and each is answered by exactly
// one imem_rvalid_i pulse at least one cycle later.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o   read request and word-aligned address
//   imem_rvalid_i, imem_rdata_i  read response
//   redirect_i, redirect_pc_i taken branch/jump and its target
//   valid_o, ready_i          decode handshake
//   instr_o, pc_o, pc_plus4_o instruction, its PC and PC+4
//   dbg_state_o               current fetch FSM state
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output fetch_state_t          dbg_state_o
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_next;
    logic [DATA_WIDTH-1:0] req_pc, req_pc_next;
    logic                  req;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  allowed;
    logic [CW-1:0]         count;
    logic [CW-1:0]         occ_next;
    logic                  queue_empty;
    logic                  queue_full;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;

    assign pop  = !queue_empty && ready_i;
    assign push = (state == WAIT) && imem_rvalid_i && !redirect_i;

    // Credit check: the queue must have room for the response of any request
    // issued now, after this cycle's pop and push have taken effect.
    assign occ_next = count - CW'(pop) + CW'(push);
    assign allowed  = (occ_next < CW'(QUEUE_DEPTH)) && !redirect_i;

    assign push_entry = '{pc: req_pc, instr: imem_rdata_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC & ALIGN_MASK;
            req_pc   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        req           = 1'b0;
        flush         = 1'b0;
        if (redirect_i) begin
            flush         = 1'b1;
            fetch_pc_next = redirect_pc_i & ALIGN_MASK;
            // A request still in flight must have its response thrown away.
            if ((state == WAIT && !imem_rvalid_i) || state == DISCARD) begin
                state_next = DISCARD;
            end else begin
                state_next = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    // imem_rvalid_i here is a protocol error and is ignored.
                    if (allowed) begin
                        req        = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (allowed) req = 1'b1;
                        else         state_next = IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid_i) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            if (req) begin
                req_pc_next   = fetch_pc;
                fetch_pc_next = fetch_pc + DATA_WIDTH'(4);
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .count      (count),
        .empty      (queue_empty),
        .full       (queue_full)
    );

    // The credit scheme must never present a word to a queue with no room.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     push |-> (!queue_full || pop));

    // Gated with reset so no request escapes while the core is held in reset.
    assign imem_req_o  = req && rst_ni;
    assign imem_addr_o = fetch_pc;
    assign valid_o     = !queue_empty;
    assign instr_o     = queue_empty ? NOP : head.instr;
    assign pc_o        = queue_empty ? '0  : head.pc;
    assign pc_plus4_o  = pc_o + DATA_WIDTH'(4);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory with
// programmable latency returns the request address as data. A vector table
// covers the streaming/stall/resume sequence; hand-written sequences cover
// redirects, PC wrap and asynchronous reset in flight.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_rvalid_i;
    logic [31:0]  imem_rdata_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         valid_o;
    logic         ready_i;
    logic [31:0]  instr_o;
    logic [31:0]  pc_o;
    logic [31:0]  pc_plus4_o;
    fetch_state_t dbg_state_o;

    fetch_unit #(
        .DATA_WIDTH  (32),
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / samples ----------------
    int n_vec = 0;
    int n_bad = 0;

    logic         s_req;
    logic [31:0]  s_addr;
    logic         s_valid;
    logic [31:0]  s_instr;
    logic [31:0]  s_pc;
    logic [31:0]  s_pc4;
    fetch_state_t s_state;

    // memory model
    int          lat = 1;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture DUT outputs mid-cycle.
    task automatic mid();
        @(negedge clk_i);
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = valid_o;
        s_instr = instr_o;
        s_pc    = pc_o;
        s_pc4   = pc_plus4_o;
        s_state = dbg_state_o;
    endtask

    // Advance to the next cycle and update the memory model from the
    // request seen in the cycle just finished.
    task automatic tick();
        @(posedge clk_i);
        #1;
        imem_rvalid_i = 1'b0;
        if (s_req) begin
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_addr = s_addr;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_addr;
                pend          = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    // Assert reset, then release it so the caller starts in cycle 0.
    task automatic do_reset(input int latency);
        rst_ni        = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b1;
        pend          = 1'b0;
        s_req         = 1'b0;
        lat           = latency;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic run_to_valid(input int budget, input logic [31:0] exp_pc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            mid();
            if (s_valid) begin
                seen = 1'b1;
                chk({name, " pc"}, s_pc, exp_pc);
                chk({name, " instr"}, s_instr, exp_pc);
            end else begin
                tick();
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no valid_o within %0d cycles", name, budget);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        rst_ni        = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b1;
        #1;

        // Streaming with 1-cycle memory, then 5 cycles of ready_i=0, then resume.
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, NOP};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h04};
        tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h08};
        tbl[10] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h0C};
        tbl[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h14};

        // ---- reset state ----
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        mid();
        chk("reset req", 32'(s_req), 32'd0);
        chk("reset valid", 32'(s_valid), 32'd0);
        chk("reset instr", s_instr, NOP);
        chk("reset pc", s_pc, 32'h0);
        chk("reset state", 32'(s_state), 32'(IDLE));

        // ---- table: stream / stall / resume ----
        do_reset(1);
        for (int i = 0; i < 13; i++) begin
            ready_i = tbl[i].ready;
            mid();
            chk($sformatf("v%0d req", i), 32'(s_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("v%0d addr", i), s_addr, tbl[i].addr);
            chk($sformatf("v%0d valid", i), 32'(s_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d pc", i), s_pc, tbl[i].pc);
            chk($sformatf("v%0d instr", i), s_instr, tbl[i].instr);
            chk($sformatf("v%0d pc4", i), s_pc4, tbl[i].pc + 32'd4);
            tick();
        end

        // ---- redirect with request to 0x8 outstanding, 3-cycle memory ----
        do_reset(3);
        for (int i = 0; i < 8; i++) begin
            mid();
            tick();
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        mid();
        chk("rd3 state before", 32'(s_state), 32'(WAIT));
        chk("rd3 req during redirect", 32'(s_req), 32'd0);
        tick();
        redirect_i = 1'b0;
        mid();
        chk("rd3 discard state", 32'(s_state), 32'(DISCARD));
        chk("rd3 valid after redirect", 32'(s_valid), 32'd0);
        chk("rd3 no req in discard", 32'(s_req), 32'd0);
        tick();
        mid();
        chk("rd3 target req", 32'(s_req), 32'd1);
        chk("rd3 target addr", s_addr, 32'h100);
        tick();
        run_to_valid(10, 32'h100, "rd3 first valid");

        // ---- redirect in the same cycle as rvalid, unaligned target ----
        do_reset(1);
        mid();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        mid();
        chk("rdv rvalid present", 32'(imem_rvalid_i), 32'd1);
        chk("rdv req during redirect", 32'(s_req), 32'd0);
        tick();
        redirect_i = 1'b0;
        mid();
        chk("rdv valid after redirect", 32'(s_valid), 32'd0);
        chk("rdv state", 32'(s_state), 32'(IDLE));
        chk("rdv target req", 32'(s_req), 32'd1);
        chk("rdv target addr", s_addr, 32'h100);
        tick();
        run_to_valid(6, 32'h100, "rdv first valid");

        // ---- PC wrap from 0xFFFF_FFFC ----
        do_reset(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        mid();
        tick();
        redirect_i = 1'b0;
        mid();
        chk("wrap req addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap req", 32'(s_req), 32'd1);
        tick();
        mid();
        chk("wrap next addr", s_addr, 32'h0);
        chk("wrap next req", 32'(s_req), 32'd1);
        tick();
        mid();
        chk("wrap valid", 32'(s_valid), 32'd1);
        chk("wrap pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap pc4", s_pc4, 32'h0);
        tick();

        // ---- asynchronous reset while a request is outstanding ----
        do_reset(3);
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            tick();
        end
        mid();
        chk("areset pre valid", 32'(s_valid), 32'd1);
        chk("areset pre state", 32'(s_state), 32'(WAIT));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("areset valid", 32'(valid_o), 32'd0);
        chk("areset instr", instr_o, NOP);
        chk("areset pc", pc_o, 32'h0);
        chk("areset req", 32'(imem_req_o), 32'd0);
        chk("areset state", 32'(dbg_state_o), 32'(IDLE));
        imem_rvalid_i = 1'b0;
        pend          = 1'b0;
        s_req         = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        mid();
        chk("areset restart req", 32'(s_req), 32'd1);
        chk("areset restart addr", s_addr, 32'h0);
        tick();
        run_to_valid(8, 32'h0, "areset first valid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core. Keeps the fetch PC, issues word reads to instruction memory with at most one request outstanding, and buffers returned words with their PCs in a small queue. Presents one instruction per cycle to decode, which drives the immediate extender and control decoder. Accepts branch/jump redirects from execute, flushing buffered and in-flight instructions.

## Interface
- DATA_WIDTH, 32, instruction/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 2, instruction queue entries (power of two, ≥2)

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- imem_req_o  out  1  read request, one cycle per request, always accepted
- imem_addr_o  out  DATA_WIDTH  word address of request, bits[1:0]=0
- imem_rvalid_i  in  1  response valid, ≥1 cycle after request
- imem_rdata_i  in  DATA_WIDTH  instruction word
- redirect_i  in  1  taken branch/jump from execute
- redirect_pc_i  in  DATA_WIDTH  target PC
- valid_o  out  1  instr_o/pc_o hold a valid instruction
- ready_i  in  1  decode accepts (pop when valid_o & ready_i)
- instr_o  out  DATA_WIDTH  instruction to decode
- pc_o  out  DATA_WIDTH  PC of instr_o
- pc_plus4_o  out  DATA_WIDTH  pc_o + 4 (JAL/JALR link)

## Operation
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (outstanding response must be dropped).
- Occupancy for credit: occ_next = count − pop + push. Request allowed when occ_next < QUEUE_DEPTH and redirect_i=0.
- IDLE: if allowed, imem_req_o=1, imem_addr_o=fetch_pc, latch req_pc=fetch_pc, fetch_pc+=4, → WAIT.
- WAIT, imem_rvalid_i=1: push {req_pc, imem_rdata_i}; if allowed, issue next request same cycle (stay WAIT), else → IDLE.
- WAIT, imem_rvalid_i=0: hold.
- Redirect (any state) has priority: queue flushed, fetch_pc ← {redirect_pc_i[31:2],2'b00}, no request this cycle. From WAIT without rvalid → DISCARD; from WAIT with rvalid (word dropped) or IDLE → IDLE; from DISCARD stay DISCARD.
- DISCARD: on imem_rvalid_i drop word, → IDLE (request may issue next cycle).
- Push and pop in the same cycle legal at full; pop on an empty queue ignored.
- imem_rvalid_i in IDLE is a protocol error: ignored.
- Empty queue: valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0, pc_plus4_o=4.
- pc arithmetic modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (async assert): state IDLE, fetch_pc=RESET_PC, queue empty, valid_o=0, instr_o=NOP, pc_o=0, imem_req_o=0 while rst_ni=0.
- First cycle after release: imem_req_o=1, imem_addr_o=RESET_PC.
- imem_req_o/imem_addr_o combinational from registered state, fetch_pc, count, ready_i, imem_rvalid_i, redirect_i.
- Queue outputs registered: word pushed in cycle N appears on instr_o in N+1. With 1-cycle memory: request cycle 0 → rvalid cycle 1 → valid_o cycle 2; steady throughput one instruction/cycle.
- Redirect in cycle N: valid_o=0 in N+1; first target request in N+1 (N+2 if DISCARD and rvalid arrives in N+1).
- Reset mid-operation: all state cleared immediately; stale response after release is not possible (memory reset too).

## Structure
- Shared core package: NOP constant 32'h0000_0013, fetch state enum (IDLE/WAIT/DISCARD), fetch_entry_t struct {pc, instr}.
- Sub-module fetch_queue: parametric synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty/full; flush overrides push.

## Test plan
- Reset release, 1-cycle memory returning addr-as-data, ready_i=1 -> addresses 0,4,8,…; valid_o from cycle 2; pc_o 0,4,8 each cycle, pc_plus4_o=pc_o+4.
- ready_i=0 for 5 cycles -> exactly QUEUE_DEPTH entries buffered, imem_req_o=0 once full; ready_i=1 -> resume with no lost/duplicated PC.
- Redirect to 32'h100 while request to 0x8 outstanding with 3-cycle latency -> 0x8 response dropped, next request 0x100, pc_o=0x100 first valid.
- Redirect same cycle as imem_rvalid_i -> returned word never appears on instr_o; redirect_pc_i=0x102 fetches 0x100.
- Fetch from 32'hFFFF_FFFC -> next request address 0; async reset asserted mid-WAIT -> valid_o=0, instr_o=NOP immediately, restart at RESET_PC.
